// File: rtl/smart_house_pkg.sv
// Shared types and default constants for the multi-zone smart house controller.
package smart_house_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCool = 2'd1,
    StHeat = 2'd2
  } zone_state_e;

  localparam int          DEFAULT_SP = 25;
  localparam int unsigned HYST       = 1;

endpackage

// File: rtl/smart_house_zone_ctrl.sv
// One climate zone: hysteretic IDLE/COOL/HEAT state machine against a setpoint.
// Optional minimum dwell in COOL/HEAT when SMART_HOUSE_MIN_DWELL_EN is defined.
module smart_house_zone_ctrl
  import smart_house_pkg::*;
#(
  parameter int unsigned TempW    = 16,
  parameter int unsigned Hyst     = 1,
  parameter int unsigned MinDwell = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [TempW-1:0] temp,
  input  logic signed [TempW-1:0] setpoint,
  output logic                    cooler,
  output logic                    heater
);

  // One extra bit keeps setpoint +/- hysteresis from wrapping at the extremes.
  localparam logic signed [TempW:0] HystX = (TempW + 1)'(Hyst);

  zone_state_e            state_q, state_d;
  logic signed [TempW:0]  temp_x, sp_x;
  logic                   too_hot, too_cold, above_sp, below_sp, exit_ok, entering;

  assign temp_x   = {temp[TempW-1], temp};
  assign sp_x     = {setpoint[TempW-1], setpoint};
  assign too_hot  = temp_x > (sp_x + HystX);
  assign too_cold = temp_x < (sp_x - HystX);
  assign above_sp = temp_x > sp_x;
  assign below_sp = temp_x < sp_x;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (too_hot) begin
          state_d = StCool;
        end else if (too_cold) begin
          state_d = StHeat;
        end
      end
      StCool: if (!above_sp && exit_ok) state_d = StIdle;
      StHeat: if (!below_sp && exit_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign entering = (state_q == StIdle) && (state_d != StIdle);

`ifdef SMART_HOUSE_MIN_DWELL_EN
  localparam int unsigned DwellW = (MinDwell > 0) ? $clog2(MinDwell + 1) : 1;

  logic [DwellW-1:0] dwell_q, dwell_d;

  // Exit is allowed on the edge at which the counter reaches zero.
  assign exit_ok = dwell_q <= DwellW'(1);

  always_comb begin
    dwell_d = dwell_q;
    if (entering) begin
      dwell_d = DwellW'(MinDwell);
    end else if (dwell_q != '0) begin
      dwell_d = dwell_q - DwellW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`else
  logic unused_dwell_cfg;
  assign unused_dwell_cfg = ^{MinDwell, entering};
  assign exit_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign cooler = (state_q == StCool);
  assign heater = (state_q == StHeat);

endmodule

// File: rtl/smart_house_zones.sv
// Multi-zone smart house top: curtain/light, doorbell ring counter, setpoint registers
// and one climate controller per zone. SMART_HOUSE_MIN_DWELL_EN enables minimum dwell.
module smart_house_zones #(
  parameter int unsigned ZONES       = 4,
  parameter int unsigned TEMP_W      = 16,
  parameter int unsigned HYST        = smart_house_pkg::HYST,
  parameter int unsigned RING_CYCLES = 8,
  parameter int          DEFAULT_SP  = smart_house_pkg::DEFAULT_SP,
  parameter int unsigned MIN_DWELL   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    isday,
  input  logic                    ring_req,
  input  logic [ZONES*TEMP_W-1:0] temp_sense,
  input  logic                    sp_wr,
  input  logic [3:0]              sp_zone,
  input  logic [TEMP_W-1:0]       sp_value,
  output logic                    music,
  output logic                    curtain,
  output logic                    light,
  output logic [ZONES-1:0]        cooler,
  output logic [ZONES-1:0]        heater
);

  localparam int unsigned RingW = $clog2(RING_CYCLES + 1);

  logic [RingW-1:0]         ring_q;
  logic signed [TEMP_W-1:0] sp_q [ZONES];

  always_ff @(posedge clock) begin
    if (!reset) begin
      curtain <= 1'b0;
      light   <= 1'b0;
    end else begin
      curtain <= isday;
      light   <= ~isday;
    end
  end

  // A request always restarts the full duration rather than extending it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ring_q <= '0;
    end else if (ring_req) begin
      ring_q <= RingW'(RING_CYCLES);
    end else if (ring_q != '0) begin
      ring_q <= ring_q - RingW'(1);
    end
  end

  assign music = (ring_q != '0);

  // Zone indices at or above ZONES match no register, so such writes drop out.
  always_ff @(posedge clock) begin
    for (int z = 0; z < int'(ZONES); z++) begin
      if (!reset) begin
        sp_q[z] <= TEMP_W'(DEFAULT_SP);
      end else if (sp_wr && (sp_zone == 4'(z))) begin
        sp_q[z] <= sp_value;
      end
    end
  end

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    smart_house_zone_ctrl #(
      .TempW    (TEMP_W),
      .Hyst     (HYST),
      .MinDwell (MIN_DWELL)
    ) u_zone (
      .clock    (clock),
      .reset    (reset),
      .temp     (temp_sense[z*TEMP_W +: TEMP_W]),
      .setpoint (sp_q[z]),
      .cooler   (cooler[z]),
      .heater   (heater[z])
    );
  end

endmodule

// File: tb/tb_smart_house_zones.sv
// Scoreboard bench for smart_house_zones: directed scenarios plus random stimulus
// checked against a behavioural model of the zone and ring rules.
module tb_smart_house_zones;

  localparam int Zones    = 4;
  localparam int TempW    = 16;
  localparam int Hyst     = 1;
  localparam int Ring     = 8;
  localparam int DefSp    = 25;
  localparam int MinDwell = 4;
  localparam int TMax     = (1 <<< (TempW - 1)) - 1;
  localparam int TMin     = -(1 <<< (TempW - 1));

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   isday = 1'b0;
  logic                   ring_req = 1'b0;
  logic                   sp_wr = 1'b0;
  logic [3:0]             sp_zone = '0;
  logic [TempW-1:0]       sp_value = '0;
  logic [Zones*TempW-1:0] temp_sense;
  logic                   music, curtain, light;
  logic [Zones-1:0]       cooler, heater;

  int t_drv [Zones];

  always_comb begin
    temp_sense = '0;
    for (int z = 0; z < Zones; z++) temp_sense[z*TempW +: TempW] = TempW'(t_drv[z]);
  end

  always #5 clock = ~clock;

  smart_house_zones #(
    .ZONES       (Zones),
    .TEMP_W      (TempW),
    .HYST        (Hyst),
    .RING_CYCLES (Ring),
    .DEFAULT_SP  (DefSp),
    .MIN_DWELL   (MinDwell)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .isday      (isday),
    .ring_req   (ring_req),
    .temp_sense (temp_sense),
    .sp_wr      (sp_wr),
    .sp_zone    (sp_zone),
    .sp_value   (sp_value),
    .music      (music),
    .curtain    (curtain),
    .light      (light),
    .cooler     (cooler),
    .heater     (heater)
  );

  typedef struct packed {
    logic             music;
    logic             curtain;
    logic             light;
    logic [Zones-1:0] cooler;
    logic [Zones-1:0] heater;
  } exp_t;

  exp_t exp_q [$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Behavioural model: zone mode 0 = idle, 1 = cooling, 2 = heating.
  int m_mode [Zones];
  int m_sp   [Zones];
  int m_age  [Zones];
  int m_ring = 0;
  bit m_cur  = 0;
  bit m_lig  = 0;

  // Drive one cycle of inputs, predict the outputs after the next edge, wait to negedge.
  task automatic apply(input int rst, input int day, input int rr, input int wr,
                       input int zn, input int val);
    exp_t e;
    reset    = (rst == 0);
    isday    = (day != 0);
    ring_req = (rr != 0);
    sp_wr    = (wr != 0);
    sp_zone  = 4'(zn);
    sp_value = TempW'(val);
    if (rst != 0) begin
      m_cur = 0;
      m_lig = 0;
      m_ring = 0;
      for (int z = 0; z < Zones; z++) begin
        m_mode[z] = 0;
        m_sp[z] = DefSp;
        m_age[z] = 0;
      end
    end else begin
      m_cur = (day != 0);
      m_lig = (day == 0);
      if (rr != 0) m_ring = Ring;
      else if (m_ring > 0) m_ring--;
      for (int z = 0; z < Zones; z++) begin
        int t;
        int sp;
        bit held;
        t = t_drv[z];
        sp = m_sp[z];
`ifdef SMART_HOUSE_MIN_DWELL_EN
        held = (m_age[z] < MinDwell);
`else
        held = 0;
`endif
        case (m_mode[z])
          0: begin
            if (t > sp + Hyst) m_mode[z] = 1;
            else if (t < sp - Hyst) m_mode[z] = 2;
            m_age[z] = (m_mode[z] != 0) ? 1 : 0;
          end
          1: begin
            if (t <= sp && !held) begin
              m_mode[z] = 0;
              m_age[z] = 0;
            end else m_age[z]++;
          end
          default: begin
            if (t >= sp && !held) begin
              m_mode[z] = 0;
              m_age[z] = 0;
            end else m_age[z]++;
          end
        endcase
      end
      if (wr != 0 && zn < Zones) m_sp[zn] = val;
    end
    e.music = (m_ring != 0);
    e.curtain = m_cur;
    e.light = m_lig;
    for (int z = 0; z < Zones; z++) begin
      e.cooler[z] = (m_mode[z] == 1);
      e.heater[z] = (m_mode[z] == 2);
    end
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every edge with a pending prediction is compared just after the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if ({music, curtain, light, cooler, heater} !== e) begin
          n_fail++;
          $display("FAIL vec%0d outputs: got music=%b curtain=%b light=%b cooler=%b heater=%b, expected music=%b curtain=%b light=%b cooler=%b heater=%b",
                   n_vec, music, curtain, light, cooler, heater,
                   e.music, e.curtain, e.light, e.cooler, e.heater);
        end
      end
    end
  end

  initial begin
    for (int z = 0; z < Zones; z++) t_drv[z] = DefSp;
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0, 0);
    idle(2);
    // Zone 0 cooling and release, then a reading inside the band
    t_drv[0] = 35; idle(2);
    t_drv[0] = 25; idle(2);
    t_drv[0] = 26; idle(3);
    // Zone 2 heating ended by a setpoint write; out-of-range write ignored
    t_drv[2] = 20; idle(2);
    apply(0, 1, 0, 1, 2, 18);
    idle(3);
    apply(0, 1, 0, 1, 7, 99);
    t_drv[2] = 30; idle(3);
    t_drv[2] = 25; apply(0, 0, 0, 1, 2, 25);
    // Ring, then a restart mid-ring
    apply(0, 0, 1, 0, 0, 0);
    idle(10);
    apply(0, 0, 1, 0, 0, 0);
    idle(4);
    apply(0, 0, 1, 0, 0, 0);
    idle(10);
    // Extreme setpoints/temperatures: no wrap
    apply(0, 0, 0, 1, 1, TMax);
    t_drv[1] = TMax; idle(3);
    apply(0, 0, 0, 1, 3, TMin);
    t_drv[3] = TMin; idle(3);
    t_drv[1] = TMin; idle(3);
    t_drv[1] = 25; t_drv[3] = 25;
    apply(0, 0, 0, 1, 1, 25);
    apply(0, 0, 0, 1, 3, 25);
    // Cool then heat through idle; reset mid-cool with music active
    t_drv[0] = 35; idle(1);
    t_drv[0] = 20; idle(8);
    t_drv[0] = 35; apply(0, 1, 1, 0, 0, 0);
    idle(2);
    apply(1, 1, 0, 0, 0, 0);
    t_drv[0] = 27; idle(3);
    // Randomised phase
    for (int n = 0; n < 3000; n++) begin
      int rst, day, rr, wr, zn, val;
      for (int z = 0; z < Zones; z++) begin
        int v;
        if ($urandom_range(0, 29) == 0) v = ($urandom_range(0, 1) == 0) ? TMax : TMin;
        else v = m_sp[z] + int'($urandom_range(0, 8)) - 4;
        if (v > TMax) v = TMax;
        if (v < TMin) v = TMin;
        t_drv[z] = v;
      end
      rst = ($urandom_range(0, 99) == 0) ? 1 : 0;
      day = int'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      wr  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      zn  = int'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) val = ($urandom_range(0, 1) == 0) ? TMax : TMin;
      else val = int'($urandom_range(18, 32));
      apply(rst, day, rr, wr, zn, val);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
